// File: rtl/vram_row_streamer.sv
// VRAM row fetcher: pulls one scaled source row over the VRAM read port and
// writes SCREEN_W expanded RGB pixels into the row buffer. Define COLOR_EXPAND_EN for bit-replicating colour expansion.
module vram_row_streamer #(
  parameter int SCREEN_W  = 640,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk_33MHz,
  input  logic        rst_n,
  input  logic        row_req,
  input  logic [8:0]  row_y,
  input  logic [9:0]  x_tl,
  input  logic [9:0]  dis_w,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  output logic        vram_we,
  output logic [9:0]  vram_x,
  output logic [23:0] vram_out,
  output logic        busy,
  output logic        row_done,
  output logic        overrun
);
  localparam int CW = $clog2(SCREEN_W + 1);
  localparam int KW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] N_PIX = CW'(SCREEN_W);
  localparam logic [CW-1:0] LAST  = CW'(SCREEN_W - 1);
  localparam logic [KW-1:0] K_MAX = KW'(MAX_OUTST);
  localparam logic [11:0]   W1    = 12'(SCREEN_W);
  localparam logic [11:0]   W2    = 12'(2 * SCREEN_W);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state;
  logic [2:0]    sync;
  logic          start, grant, rv_ok;
  logic [8:0]    row_q;
  logic [9:0]    src_x, dis_w_q, rem, src_nx, rem_nx;
  logic [11:0]   acc;
  logic [CW-1:0] issued, issued_n, returned;
  logic [KW-1:0] credits, credits_n;
  logic          mask_unused;

  assign mask_unused = mem_rdata[15];
  assign start     = sync[1] & ~sync[2];
  assign grant     = mem_req & mem_gnt;
  assign rv_ok     = mem_rvalid & (credits != '0);
  assign credits_n = credits + KW'(grant) - KW'(rv_ok);
  assign issued_n  = issued + CW'(grant);
  assign mem_addr  = {row_q, src_x};

  // Bresenham-style step: rem holds (dis_w*i) mod SCREEN_W; dis_w < 2*SCREEN_W
  // so the quotient advances by at most 2 per output pixel.
  always_comb begin
    acc    = 12'(rem) + 12'(dis_w_q);
    src_nx = src_x;
    rem_nx = acc[9:0];
    if (acc >= W2) begin
      src_nx = src_x + 10'd2;
      rem_nx = 10'(acc - W2);
    end else if (acc >= W1) begin
      src_nx = src_x + 10'd1;
      rem_nx = 10'(acc - W1);
    end
  end

  function automatic logic [7:0] c8(input logic [4:0] c);
`ifdef COLOR_EXPAND_EN
    return {c, c[4:2]};
`else
    return {c, 3'b000};
`endif
  endfunction

  always_ff @(posedge clk_33MHz or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sync     <= '0;
      row_q    <= '0;
      src_x    <= '0;
      dis_w_q  <= '0;
      rem      <= '0;
      issued   <= '0;
      returned <= '0;
      credits  <= '0;
      mem_req  <= 1'b0;
      vram_we  <= 1'b0;
      vram_x   <= '0;
      vram_out <= '0;
      busy     <= 1'b0;
      row_done <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      sync     <= {sync[1:0], row_req};
      credits  <= credits_n;
      vram_we  <= 1'b0;
      row_done <= 1'b0;
      if (row_done) busy <= 1'b0;
      // busy still covers the row_done cycle, so a start there is an overrun too
      if (start && busy) overrun <= 1'b1;
      if (rv_ok) begin
        vram_we  <= 1'b1;
        vram_x   <= 10'(returned);
        vram_out <= {c8(mem_rdata[14:10]), c8(mem_rdata[9:5]), c8(mem_rdata[4:0])};
        returned <= returned + CW'(1);
        if (returned == LAST) begin
          row_done <= 1'b1;
          state    <= IDLE;
        end
      end
      case (state)
        IDLE: if (start && !busy) begin
          state    <= ISSUE;
          busy     <= 1'b1;
          row_q    <= row_y;
          src_x    <= x_tl;
          dis_w_q  <= dis_w;
          rem      <= '0;
          issued   <= '0;
          returned <= '0;
          mem_req  <= 1'b1;
        end
        ISSUE: begin
          if (grant) begin
            src_x <= src_nx;
            rem   <= rem_nx;
          end
          issued  <= issued_n;
          mem_req <= (credits_n < K_MAX) && (issued_n < N_PIX);
          if (issued_n == N_PIX) state <= DRAIN;
        end
        default: ;
      endcase
    end
  end
endmodule
